// File: rtl/ysyx_23060020_pipe_reg.sv
// ysyx_23060020_pipe_reg: valid/ready pipeline register stage.
// Default build is a single-entry stage whose in_ready follows out_ready
// combinationally. Defining YSYX_23060020_PIPE_REG_SKID_EN adds a second
// (skid) entry, so in_ready comes straight from a flop and never depends
// on out_ready. occ reports how many words the stage currently holds.
module ysyx_23060020_pipe_reg #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [1:0]        occ
);

`ifdef YSYX_23060020_PIPE_REG_SKID_EN
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MAIN  = 2'd1,
        SKID  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MAIN  = 2'd1
    } state_t;
`endif

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   main_q;
    logic [WIDTH-1:0]   main_d;
    logic               out_valid_q;
    logic               out_valid_d;
    logic               ready_int;
    logic               in_xfer;
    logic               out_xfer;

`ifdef YSYX_23060020_PIPE_REG_SKID_EN
    logic [WIDTH-1:0]   skid_q;
    logic [WIDTH-1:0]   skid_d;
    logic               in_ready_q;
    logic               in_ready_d;

    // With a skid entry available, upstream only ever has to stall when both
    // entries are full, which is known one cycle ahead from the next state.
    assign ready_int = in_ready_q;
`else
    // Single entry: a word can be taken whenever the held one is leaving.
    assign ready_int = !out_valid_q || out_ready;
`endif

    assign in_xfer   = in_valid && ready_int;
    assign out_xfer  = out_valid_q && out_ready;

    assign in_ready  = ready_int;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occ       = state_q;

    // Next-state and data-register update; flush wins over any transfer and
    // leaves the data registers untouched so only the valid state is dropped.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef YSYX_23060020_PIPE_REG_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d = MAIN;
                        main_d  = in_data;
                    end
                end
                MAIN: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
`ifdef YSYX_23060020_PIPE_REG_SKID_EN
                    end else if (in_xfer) begin
                        state_d = SKID;
                        skid_d  = in_data;
`endif
                    end
                end
`ifdef YSYX_23060020_PIPE_REG_SKID_EN
                SKID: begin
                    if (out_xfer) begin
                        state_d = MAIN;
                        main_d  = skid_q;
                    end
                end
`endif
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        out_valid_d = (state_d != EMPTY);
`ifdef YSYX_23060020_PIPE_REG_SKID_EN
        in_ready_d  = (state_d != SKID);
`endif
    end

    // State and data registers; low rst restores the empty, ready state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= EMPTY;
            main_q      <= RESET_VAL;
            out_valid_q <= 1'b0;
`ifdef YSYX_23060020_PIPE_REG_SKID_EN
            skid_q      <= RESET_VAL;
            in_ready_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            out_valid_q <= out_valid_d;
`ifdef YSYX_23060020_PIPE_REG_SKID_EN
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
`endif
        end
    end

endmodule

// File: tb/tb_ysyx_23060020_pipe_reg.sv
// Self-checking bench for ysyx_23060020_pipe_reg: a vector table for reset,
// simple transfers and flush, then hand-written multi-cycle sequences.
module tb_ysyx_23060020_pipe_reg;

    localparam int          WIDTH = 32;
    localparam logic [31:0] RV    = 32'hC0DE_0001;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [1:0]        occ;

    int checks;
    int failures;

    ysyx_23060020_pipe_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occ       (occ)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        chk;
        logic        rst;
        logic        flush;
        logic        iv;
        logic [31:0] din;
        logic        ordy;
        logic        exp_ov;
        logic [31:0] exp_od;
        logic [1:0]  exp_occ;
        logic        exp_rdy;
    } vec_t;

    vec_t vecs[12];

    // Inputs change just after the falling edge, outputs are checked 1 unit
    // later, well away from the rising edge that commits the next state.
    task automatic applyStimulus(input logic r, input logic f, input logic iv,
                                 input logic [31:0] d, input logic ordy);
        @(negedge clk);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic ov, input logic [31:0] od,
                            input logic [1:0] oc, input logic rdy);
        checkOutput({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        checkOutput({tag, ".out_data"},  out_data, od);
        checkOutput({tag, ".occ"},       {30'd0, occ}, {30'd0, oc});
        checkOutput({tag, ".in_ready"},  {31'd0, in_ready}, {31'd0, rdy});
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        //          chk   rst   flush iv    din            ordy  ov    od             occ   rdy
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, RV,            2'd0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, RV,            2'd0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, RV,            2'd0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h10,       1'b0, 1'b0, RV,            2'd0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h10,        2'd1, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h10,        2'd0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h20,       1'b1, 1'b0, 32'h10,        2'd0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h21,       1'b1, 1'b1, 32'h20,        2'd1, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h22,       1'b1, 1'b1, 32'h21,        2'd1, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h21,        2'd0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h30,       1'b1, 1'b0, 32'h21,        2'd0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, RV,            2'd0, 1'b1};

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].din, vecs[i].ordy);
            if (vecs[i].chk)
                checkAll($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_od,
                         vecs[i].exp_occ, vecs[i].exp_rdy);
        end

        // Streaming 1..100: each word must appear the very next cycle
        for (int k = 1; k <= 100; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 32'(k), 1'b1);
            if (k > 1) begin
                checkOutput($sformatf("stream%0d.out_data", k - 1), out_data, 32'(k - 1));
                checkOutput($sformatf("stream%0d.out_valid", k - 1), {31'd0, out_valid}, 32'd1);
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll("stream_last", 1'b1, 32'd100, 2'd1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll("stream_drain", 1'b0, 32'd100, 2'd0, 1'b1);

`ifdef YSYX_23060020_PIPE_REG_SKID_EN
        // Backpressure fills main then skid; words drain in order
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
        checkAll("bp_empty", 1'b0, 32'd100, 2'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
        checkAll("bp_main", 1'b1, 32'hA, 2'd1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkAll("bp_skid", 1'b1, 32'hA, 2'd2, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll("bp_out_a", 1'b1, 32'hA, 2'd2, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll("bp_out_b", 1'b1, 32'hB, 2'd1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll("bp_done", 1'b0, 32'hB, 2'd0, 1'b1);

        // Flush with two words held and a third offered
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h11, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h22, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h33, 1'b0);
        checkAll("fl_full", 1'b1, 32'h11, 2'd2, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll("fl_after", 1'b0, 32'h11, 2'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll("fl_quiet", 1'b0, 32'h11, 2'd0, 1'b1);
`else
        // Single entry: in_ready drops under backpressure and follows out_ready
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h40, 1'b1);
        checkAll("ns_empty", 1'b0, 32'd100, 2'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h41, 1'b0);
        checkAll("ns_stall1", 1'b1, 32'h40, 2'd1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h41, 1'b0);
        checkAll("ns_stall2", 1'b1, 32'h40, 2'd1, 1'b0);
        out_ready = 1'b1;
        #1;
        checkOutput("ns_comb.in_ready", {31'd0, in_ready}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll("ns_next", 1'b1, 32'h41, 2'd1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll("ns_done", 1'b0, 32'h41, 2'd0, 1'b1);
`endif

        // Reset while a word is held: it must never be delivered
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h55, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("mr_held.out_data", out_data, 32'h55);
        checkOutput("mr_held.occ", {30'd0, occ}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll("mr_after", 1'b0, RV, 2'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll("mr_quiet", 1'b0, RV, 2'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
